tree_path_encoder: RTL and testbench

- Transmit-side counterpart of the tree message parser.
- Takes requests of the form "write payload at node path P" and serialises them into a token stream of OPEN / CLOSE / DATA tokens carrying field identifiers.
- The downstream receiver rebuilds the same message hierarchy from this stream.
- Keeps the currently open path as a stack. Only the delta between the open path and the requested path is emitted: close the divergent levels, open the new ones, then send the payload.

---
 rtl/tree_path_encoder.sv | 218 +++++++++++++++++++++
 tb/tb_tree_path_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tree_path_encoder.sv
// tree_path_encoder
//   Serialises "write payload at node path P" requests into an OPEN / CLOSE /
//   DATA token stream. The currently open path is kept as a stack. Each request
//   emits only the difference between that stack and the requested path:
//   first the divergent levels are closed, then the new levels are opened,
//   and finally the payload is sent.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_path         node id per level, level 0 at the LSBs, 0 = null node
//   req_data         payload for the deepest node of req_path
//   tok_valid/ready  token handshake
//   tok_kind         0=OPEN 1=CLOSE 2=DATA
//   tok_id           field id of the token's node
//   tok_data         payload on DATA tokens, 0 otherwise
//   cur_depth        number of currently open levels
//   flush            (only with TREE_ENC_FLUSH_EN) close every open level
//
// Build option
//   TREE_ENC_FLUSH_EN  adds the flush input. Without it, a request whose
//                      level-0 node is null has the same effect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request; req_ready high unless flush is seen
// S_CLOSE | closing stack levels cur_depth-1 down to the common prefix
// S_OPEN  | opening requested levels from cur_depth up to rd-1
// S_DATA  | sending the payload token for the deepest requested node
module tree_path_encoder #(
  parameter int NUM_LEVELS = 2,
  parameter int NODE_W     = 2,
  parameter int ID_W       = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_NODES  = 3,
  parameter logic [NUM_NODES*ID_W-1:0] FIELD_ID_TABLE = {5'd4, 5'd1, 5'd0},
  localparam int DEPTH_W   = $clog2(NUM_LEVELS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef TREE_ENC_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [NUM_LEVELS*NODE_W-1:0] req_path,
  input  logic [DATA_W-1:0]            req_data,
  output logic                         tok_valid,
  input  logic                         tok_ready,
  output logic [1:0]                   tok_kind,
  output logic [ID_W-1:0]              tok_id,
  output logic [DATA_W-1:0]            tok_data,
  output logic [DEPTH_W-1:0]           cur_depth
);

  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

  localparam logic [1:0] KIND_OPEN  = 2'd0;
  localparam logic [1:0] KIND_CLOSE = 2'd1;
  localparam logic [1:0] KIND_DATA  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_CLOSE, S_OPEN, S_DATA} state_t;

  state_t state, state_nxt;

  logic [NODE_W-1:0]  req_node [NUM_LEVELS];
  logic [NODE_W-1:0]  stack    [NUM_LEVELS];
  logic [NODE_W-1:0]  lat_path [NUM_LEVELS];
  logic [DATA_W-1:0]  lat_data;
  logic [DEPTH_W-1:0] lat_rd;
  logic [DEPTH_W-1:0] lat_p;

  logic [DEPTH_W-1:0] req_rd, req_p, acc_rd, acc_p;
  logic               run_rd, run_p;
  logic               flush_req;
  logic               start;
  logic               tok_fire;
  logic [LVL_W-1:0]   close_idx, open_idx, data_idx;

  function automatic logic [ID_W-1:0] field_id(input logic [NODE_W-1:0] node);
    field_id = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      if (int'(node) == n) field_id = FIELD_ID_TABLE[n*ID_W +: ID_W];
    end
  endfunction

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_split
    assign req_node[g] = req_path[g*NODE_W +: NODE_W];
  end

`ifdef TREE_ENC_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Request depth stops at the first null node; the common prefix stops at
  // the first level where the open stack and the request disagree.
  always_comb begin
    req_rd = '0;
    req_p  = '0;
    run_rd = 1'b1;
    run_p  = 1'b1;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (run_rd && req_node[i] != '0) req_rd = DEPTH_W'(i + 1);
      else                             run_rd = 1'b0;
    end
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (run_p && i < int'(cur_depth) && i < int'(req_rd) && stack[i] == req_node[i])
        req_p = DEPTH_W'(i + 1);
      else
        run_p = 1'b0;
    end
  end

  // A flush behaves like an empty request with no shared prefix.
  assign acc_rd   = flush_req ? '0 : req_rd;
  assign acc_p    = flush_req ? '0 : req_p;
  assign start    = (state == S_IDLE) && (flush_req || req_valid);
  assign tok_fire = tok_valid && tok_ready;

  assign close_idx = LVL_W'(cur_depth - DEPTH_W'(1));
  assign open_idx  = LVL_W'(cur_depth);
  assign data_idx  = LVL_W'(lat_rd - DEPTH_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; empty phases are skipped without an idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cur_depth > acc_p)   state_nxt = S_CLOSE;
          else if (acc_p < acc_rd) state_nxt = S_OPEN;
          else if (acc_rd != '0)   state_nxt = S_DATA;
          else                     state_nxt = S_IDLE;
        end
      end
      S_CLOSE: begin
        if (tok_fire && (cur_depth - DEPTH_W'(1)) == lat_p) begin
          if (lat_p < lat_rd)      state_nxt = S_OPEN;
          else if (lat_rd != '0)   state_nxt = S_DATA;
          else                     state_nxt = S_IDLE;
        end
      end
      S_OPEN: begin
        if (tok_fire && (cur_depth + DEPTH_W'(1)) == lat_rd) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (tok_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, open-path stack and depth counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        stack[i]    <= '0;
        lat_path[i] <= '0;
      end
      lat_data  <= '0;
      lat_rd    <= '0;
      lat_p     <= '0;
      cur_depth <= '0;
    end else begin
      if (start) begin
        for (int i = 0; i < NUM_LEVELS; i++) lat_path[i] <= req_node[i];
        lat_data <= req_data;
        lat_rd   <= acc_rd;
        lat_p    <= acc_p;
      end
      if (state == S_CLOSE && tok_fire) cur_depth <= cur_depth - DEPTH_W'(1);
      if (state == S_OPEN && tok_fire) begin
        stack[open_idx] <= lat_path[open_idx];
        cur_depth       <= cur_depth + DEPTH_W'(1);
      end
    end
  end

  // Outputs depend only on registered state, so they hold under backpressure.
  always_comb begin
    req_ready = 1'b0;
    tok_valid = 1'b0;
    tok_kind  = KIND_OPEN;
    tok_id    = '0;
    tok_data  = '0;
    case (state)
      S_IDLE: begin
        req_ready = !flush_req;
      end
      S_CLOSE: begin
        tok_valid = 1'b1;
        tok_kind  = KIND_CLOSE;
        tok_id    = field_id(stack[close_idx]);
      end
      S_OPEN: begin
        tok_valid = 1'b1;
        tok_kind  = KIND_OPEN;
        tok_id    = field_id(lat_path[open_idx]);
      end
      S_DATA: begin
        tok_valid = 1'b1;
        tok_kind  = KIND_DATA;
        tok_id    = field_id(lat_path[data_idx]);
        tok_data  = lat_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tree_path_encoder.sv
module tb_tree_path_encoder;

  logic        clk;
  logic        rst_n;
`ifdef TREE_ENC_FLUSH_EN
  logic        flush;
`endif
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_path;
  logic [31:0] req_data;
  logic        tok_valid;
  logic        tok_ready;
  logic [1:0]  tok_kind;
  logic [4:0]  tok_id;
  logic [31:0] tok_data;
  logic [1:0]  cur_depth;

  tree_path_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef TREE_ENC_FLUSH_EN
    .flush     (flush),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_path  (req_path),
    .req_data  (req_data),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_kind  (tok_kind),
    .tok_id    (tok_id),
    .tok_data  (tok_data),
    .cur_depth (cur_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          id;
    logic [31:0] data;
    int          depth;
  } tok_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   open_q[$];
  tok_t exp_q[$];
  int   final_depth;
  int   stall_max = 0;
  int   force_idx = -1;
  int   force_n   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fid(input int node);
    int lut[3] = '{0, 1, 4};
    return (node >= 0 && node < 3) ? lut[node] : 0;
  endfunction

  // Reference: list the tokens that move the open path to the requested path.
  task automatic model_req(input int n0, input int n1, input logic [31:0] d, input bit is_flush);
    int rp[$];
    int p;
    rp = {};
    if (!is_flush && n0 != 0) begin
      rp.push_back(n0);
      if (n1 != 0) rp.push_back(n1);
    end
    p = 0;
    while (!is_flush && p < open_q.size() && p < rp.size() && open_q[p] == rp[p]) p++;
    for (int l = open_q.size() - 1; l >= p; l--)
      exp_q.push_back('{kind: 1, id: fid(open_q[l]), data: 32'h0, depth: l + 1});
    for (int l = p; l < rp.size(); l++)
      exp_q.push_back('{kind: 0, id: fid(rp[l]), data: 32'h0, depth: l});
    if (rp.size() > 0)
      exp_q.push_back('{kind: 2, id: fid(rp[rp.size()-1]), data: d, depth: rp.size()});
    open_q = rp;
    final_depth = rp.size();
  endtask

  task automatic check_tok(input tok_t t, input string pfx);
    check({pfx, "_valid"}, 64'(tok_valid), 64'(1));
    check({pfx, "_kind"},  64'(tok_kind),  64'(t.kind));
    check({pfx, "_id"},    64'(tok_id),    64'(t.id));
    check({pfx, "_data"},  64'(tok_data),  64'(t.data));
    check({pfx, "_depth"}, 64'(cur_depth), 64'(t.depth));
    check({pfx, "_rdy"},   64'(req_ready), 64'(0));
  endtask

  // Called at the negedge of cycle N+1: the first token must already be valid,
  // and each later token must follow with no gap.
  task automatic drain();
    int idx = 0;
    int stalls;
    tok_t t;
    while (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      stalls = (idx == force_idx) ? force_n : int'($urandom_range(stall_max, 0));
      for (int s = 0; s < stalls; s++) begin
        tok_ready = 1'b0;
        check_tok(t, "stall");
        @(negedge clk);
      end
      tok_ready = 1'b1;
      check_tok(t, "tok");
      @(negedge clk);
      idx++;
    end
    check("end_valid", 64'(tok_valid), 64'(0));
    check("end_ready", 64'(req_ready), 64'(1));
    check("end_depth", 64'(cur_depth), 64'(final_depth));
    force_idx = -1;
  endtask

  task automatic send_req(input int n0, input int n1, input logic [31:0] d);
    req_valid = 1'b1;
    req_path  = {2'(n1), 2'(n0)};
    req_data  = d;
    check("req_ready", 64'(req_ready), 64'(1));
    model_req(n0, n1, d, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_path  = '0;
    req_data  = '0;
    drain();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, 64'(tok_valid), 64'(0));
    check({pfx, "_ready"}, 64'(req_ready), 64'(1));
    check({pfx, "_kind"},  64'(tok_kind),  64'(0));
    check({pfx, "_id"},    64'(tok_id),    64'(0));
    check({pfx, "_data"},  64'(tok_data),  64'(0));
    check({pfx, "_depth"}, 64'(cur_depth), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_path  = '0;
    req_data  = '0;
    tok_ready = 1'b1;
`ifdef TREE_ENC_FLUSH_EN
    flush     = 1'b0;
`endif
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // {0,1}: OPEN id1 held under a 3-cycle stall, then DATA id1 0xA5
    force_idx = 0;
    force_n   = 3;
    send_req(1, 0, 32'hA5);
    // {2,1}: OPEN id4, DATA id4
    send_req(1, 2, 32'h11);
    // same path again: DATA only
    send_req(1, 2, 32'h22);
    // back to {0,1}: CLOSE id4, DATA id1
    send_req(1, 0, 32'h33);
    // {2,1} then rd=0: CLOSE id4, CLOSE id1
    send_req(1, 2, 32'h44);
    send_req(0, 0, 32'h55);
    // empty request at depth 0: no tokens
    send_req(0, 2, 32'h66);

`ifdef TREE_ENC_FLUSH_EN
    send_req(1, 2, 32'h77);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_path  = 4'b0110;
    check("flush_ready", 64'(req_ready), 64'(0));
    model_req(0, 0, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    req_path  = '0;
    drain();
`endif

    // reset in the middle of a CLOSE sequence
    send_req(1, 2, 32'h88);
    req_valid = 1'b1;
    req_path  = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_kind",  64'(tok_kind),  64'(1));
    check("mid_depth", 64'(cur_depth), 64'(2));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    open_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_req(1, 0, 32'h99);

    stall_max = 2;
    for (int k = 0; k < 40; k++)
      send_req(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom);
    stall_max = 0;
    for (int k = 0; k < 20; k++)
      send_req(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
